ex_mem_elastic_stage: RTL and testbench



---
 rtl/ex_mem_elastic_stage.sv | 124 ++++++++++++
 tb/tb_ex_mem_elastic_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_elastic_stage.sv
// rtl/ex_mem_elastic_stage.sv - valid/ready pipeline stage register with optional skid buffer,
// flush/bubble insertion and saturating stall counter.
module ex_mem_elastic_stage #(
  parameter int                CTRL_W   = 16,
  parameter int                DATA_W   = 101,
  parameter int                PC_W     = 32,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  parameter int                SKID_EN  = 1,
  parameter int                CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } occ_t;

  occ_t              state;
  logic              out_valid_r;
  logic              skid_free_r;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [PC_W-1:0]   main_pc;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [PC_W-1:0]   skid_pc;
  logic              in_xfer;
  logic              out_xfer;

  // Without the skid buffer, ready looks through to the downstream; FULL is then unreachable
  // because an input can only be taken while the held entry is leaving.
  assign in_ready  = (SKID_EN != 0) ? skid_free_r : (out_ready || !out_valid_r);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid_r && out_ready;

  assign out_valid = out_valid_r;
  assign out_ctrl  = out_valid_r ? main_ctrl : CTRL_RST;
  assign out_data  = main_data;
  assign out_pc    = main_pc;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_EMPTY;
      out_valid_r <= 1'b0;
      skid_free_r <= 1'b1;
      main_ctrl   <= CTRL_RST;
      main_data   <= '0;
      main_pc     <= '0;
      skid_ctrl   <= CTRL_RST;
      skid_data   <= '0;
      skid_pc     <= '0;
    end else if (flush) begin
      state       <= S_EMPTY;
      out_valid_r <= 1'b0;
      skid_free_r <= 1'b1;
    end else begin
      case (state)
        S_EMPTY: begin
          if (in_xfer) begin
            main_ctrl   <= in_ctrl;
            main_data   <= in_data;
            main_pc     <= in_pc;
            out_valid_r <= 1'b1;
            state       <= S_ONE;
          end
        end
        S_ONE: begin
          if (in_xfer && out_xfer) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
            main_pc   <= in_pc;
          end else if (in_xfer) begin
            skid_ctrl   <= in_ctrl;
            skid_data   <= in_data;
            skid_pc     <= in_pc;
            skid_free_r <= 1'b0;
            state       <= S_FULL;
          end else if (out_xfer) begin
            out_valid_r <= 1'b0;
            state       <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_xfer) begin
            main_ctrl   <= skid_ctrl;
            main_data   <= skid_data;
            main_pc     <= skid_pc;
            skid_free_r <= 1'b1;
            state       <= S_ONE;
          end
        end
        default: begin
          state       <= S_EMPTY;
          out_valid_r <= 1'b0;
          skid_free_r <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (out_valid_r && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ex_mem_elastic_stage.sv
// tb/tb_ex_mem_elastic_stage.sv - self-checking bench for ex_mem_elastic_stage
// (skid and non-skid variants, flush, reset, stall counter saturation).
module tb_ex_mem_elastic_stage;
  localparam int CW = 16;
  localparam int DW = 101;
  localparam int PW = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [PW-1:0] in_pc, out_pc;
  logic [15:0]   stall_cnt;

  logic          in_ready_b, out_valid_b;
  logic [CW-1:0] out_ctrl_b;
  logic [DW-1:0] out_data_b;
  logic [PW-1:0] out_pc_b;
  logic [3:0]    stall_cnt_b;

  logic          in_valid_c, in_ready_c, out_valid_c, out_ready_c, flush_c;
  logic [CW-1:0] in_ctrl_c, out_ctrl_c;
  logic [DW-1:0] in_data_c, out_data_c;
  logic [PW-1:0] in_pc_c, out_pc_c;
  logic [15:0]   stall_cnt_c;

  ex_mem_elastic_stage #(.SKID_EN(1), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .out_pc(out_pc), .stall_cnt(stall_cnt));

  ex_mem_elastic_stage #(.SKID_EN(1), .CNT_W(4)) dut_cnt4 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_ctrl(out_ctrl_b),
    .out_data(out_data_b), .out_pc(out_pc_b), .stall_cnt(stall_cnt_b));

  ex_mem_elastic_stage #(.SKID_EN(0), .CNT_W(16)) dut_noskid (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .in_ctrl(in_ctrl_c), .in_data(in_data_c), .in_pc(in_pc_c), .flush(flush_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .out_ctrl(out_ctrl_c),
    .out_data(out_data_c), .out_pc(out_pc_c), .stall_cnt(stall_cnt_c));

  typedef struct {
    logic       iv;
    logic       ordy;
    logic       fl;
    logic [7:0] d;
    logic       ev;
    logic       eir;
    logic [7:0] ed;
    logic [15:0] esc;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic iv, logic ordy, logic fl, logic [7:0] d,
                              logic ev, logic eir, logic [7:0] ed, logic [15:0] esc);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.d = d;
    v.ev = ev; v.eir = eir; v.ed = ed; v.esc = esc;
    return v;
  endfunction

  function automatic logic [CW-1:0] ctrl_of(logic [7:0] d);
    return {8'hC0, d};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clock);
    in_valid  = v.iv;
    out_ready = v.ordy;
    flush     = v.fl;
    in_data   = DW'(v.d);
    in_pc     = {22'b0, v.d, 2'b00};
    in_ctrl   = ctrl_of(v.d);
    @(posedge clock);
    #1;
    check($sformatf("v%0d.out_valid", idx), 128'(out_valid), 128'(v.ev));
    check($sformatf("v%0d.in_ready", idx), 128'(in_ready), 128'(v.eir));
    check($sformatf("v%0d.out_ctrl", idx), 128'(out_ctrl),
          v.ev ? 128'(ctrl_of(v.ed)) : 128'(0));
    check($sformatf("v%0d.stall_cnt", idx), 128'(stall_cnt), 128'(v.esc));
    if (v.ev) begin
      check($sformatf("v%0d.out_data", idx), 128'(out_data), 128'(v.ed));
      check($sformatf("v%0d.out_pc", idx), 128'(out_pc), 128'({v.ed, 2'b00}));
    end
  endtask

  int n1;
  logic [15:0] next_id;
  logic [15:0] q[$];
  logic [15:0] exp_id;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_data = '0; in_pc = '0; in_ctrl = '0;
    in_valid_c = 1'b0; out_ready_c = 1'b0; flush_c = 1'b0;
    in_data_c = '0; in_pc_c = '0; in_ctrl_c = '0;

    // stream 8 entries at full rate, then drain
    for (int k = 0; k < 8; k++) tbl.push_back(mk(1, 1, 0, 8'(k), 1, 1, 8'(k), 16'd0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'h00, 16'd0));
    // back-pressure: skid fills, in_ready drops, then drains in order
    tbl.push_back(mk(1, 0, 0, 8'h10, 1, 1, 8'h10, 16'd0));
    tbl.push_back(mk(1, 0, 0, 8'h11, 1, 0, 8'h10, 16'd1));
    tbl.push_back(mk(1, 0, 0, 8'h12, 1, 0, 8'h10, 16'd2));
    tbl.push_back(mk(1, 0, 0, 8'h12, 1, 0, 8'h10, 16'd3));
    tbl.push_back(mk(1, 1, 0, 8'h12, 1, 1, 8'h11, 16'd3));
    tbl.push_back(mk(1, 1, 0, 8'h12, 1, 1, 8'h12, 16'd3));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'h00, 16'd3));
    // flush while FULL with 0x77 presented
    tbl.push_back(mk(1, 0, 0, 8'h20, 1, 1, 8'h20, 16'd3));
    tbl.push_back(mk(1, 0, 0, 8'h21, 1, 0, 8'h20, 16'd4));
    tbl.push_back(mk(1, 0, 1, 8'h77, 0, 1, 8'h00, 16'd5));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'h00, 16'd5));
    tbl.push_back(mk(1, 1, 0, 8'h30, 1, 1, 8'h30, 16'd5));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'h00, 16'd5));
    // fill before the mid-stream reset
    tbl.push_back(mk(1, 0, 0, 8'h40, 1, 1, 8'h40, 16'd5));
    tbl.push_back(mk(1, 0, 0, 8'h41, 1, 0, 8'h40, 16'd6));
    n1 = tbl.size();
    tbl.push_back(mk(1, 1, 0, 8'h50, 1, 1, 8'h50, 16'd0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'h00, 16'd0));
    tbl.push_back(mk(1, 0, 0, 8'h60, 1, 1, 8'h60, 16'd0));

    repeat (2) @(posedge clock);
    #1;
    check("rst.out_valid", 128'(out_valid), 128'(0));
    check("rst.out_ctrl", 128'(out_ctrl), 128'(0));
    check("rst.out_data", 128'(out_data), 128'(0));
    check("rst.out_pc", 128'(out_pc), 128'(0));
    check("rst.stall_cnt", 128'(stall_cnt), 128'(0));
    check("rst.in_ready", 128'(in_ready), 128'(1));
    reset_n = 1'b1;

    for (int i = 0; i < n1; i++) apply(tbl[i], i);

    // one-cycle reset with a FULL stage and a live input
    @(negedge clock);
    reset_n = 1'b0; in_valid = 1'b1; in_data = DW'(8'h42); out_ready = 1'b0;
    @(posedge clock);
    #1;
    check("midrst.out_valid", 128'(out_valid), 128'(0));
    check("midrst.out_ctrl", 128'(out_ctrl), 128'(0));
    check("midrst.out_data", 128'(out_data), 128'(0));
    check("midrst.out_pc", 128'(out_pc), 128'(0));
    check("midrst.stall_cnt", 128'(stall_cnt), 128'(0));
    check("midrst.stall_cnt_b", 128'(stall_cnt_b), 128'(0));
    check("midrst.in_ready", 128'(in_ready), 128'(1));
    reset_n = 1'b1; in_valid = 1'b0;

    for (int i = n1; i < tbl.size(); i++) apply(tbl[i], i);

    // hold a valid entry against a stalled downstream; 4-bit counter must pin at 15
    for (int i = 0; i < 20; i++) begin
      apply(mk(0, 0, 0, 8'h00, 1, 1, 8'h60, 16'(i + 1)), 100 + i);
      check($sformatf("sat%0d.stall_cnt_b", i), 128'(stall_cnt_b),
            128'((i + 1 > 15) ? 15 : i + 1));
    end
    apply(mk(0, 1, 0, 8'h00, 0, 1, 8'h00, 16'd20), 200);

    // non-skid variant: random traffic against a scoreboard
    next_id = 16'd1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clock);
      in_valid_c  = 1'($urandom_range(0, 1));
      out_ready_c = 1'($urandom_range(0, 1));
      in_data_c   = DW'(next_id);
      in_pc_c     = PW'({next_id, 2'b00});
      in_ctrl_c   = next_id;
      #1;
      check($sformatf("c%0d.in_ready", cyc), 128'(in_ready_c),
            128'(out_ready_c || !out_valid_c));
      if (out_valid_c && out_ready_c) begin
        if (q.size() == 0) begin
          check($sformatf("c%0d.spurious_out", cyc), 128'(out_valid_c), 128'(0));
        end else begin
          exp_id = q.pop_front();
          check($sformatf("c%0d.out_data", cyc), 128'(out_data_c), 128'(exp_id));
          check($sformatf("c%0d.out_pc", cyc), 128'(out_pc_c), 128'({exp_id, 2'b00}));
          check($sformatf("c%0d.out_ctrl", cyc), 128'(out_ctrl_c), 128'(exp_id));
        end
      end
      if (in_valid_c && in_ready_c) begin
        q.push_back(next_id);
        next_id = next_id + 16'd1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
